// File: rtl/mac_issue_ctrl.sv
// mac_issue_ctrl: issue and stage control for a three-stage FMA pipeline.
// S1 = multiply/align, S2 = grand add/LZA, S3 = normalize/round. The block
// keeps one valid bit and a small sideband record per stage and produces
// the datapath load enables. Stages advance independently, so bubbles
// collapse and throughput stays at one operation per cycle.
//
// Handshake rule (both ports): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds valid and payload until
// the transfer. Ready never depends on valid of the same port.
// req_ready_o is combinational from the pipe state, res_ready_i and flush_i.
// res_valid_o and res_* come straight from registers and stay stable while
// they wait for res_ready_i.
module mac_issue_ctrl #(
    parameter int PARM_TAG = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,

    // request side
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [1:0]          req_op_i,
    input  logic [2:0]          req_rm_i,
    input  logic [PARM_TAG-1:0] req_tag_i,
    input  logic                req_sign_a_i,
    input  logic                req_sign_b_i,
    input  logic                req_sign_c_i,
    input  logic                req_special_i,

    input  logic                flush_i,

    // datapath stage load enables
    output logic                s1_en_o,
    output logic                s2_en_o,
    output logic                s3_en_o,

    // S2 datapath interaction
    output logic                s2_sub_sign_o,
    input  logic                s2_sign_flip_i,

    // result side, describes the operation held in S3
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [PARM_TAG-1:0] res_tag_o,
    output logic [2:0]          res_rm_o,
    output logic                res_special_o,
    output logic                res_sign_flip_o,

    // status
    output logic [1:0]          occupancy_o,
    output logic                busy_o
);

    // stage valid bits
    logic                s1_valid;
    logic                s2_valid;
    logic                s3_valid;

    // stage sideband records
    logic [PARM_TAG-1:0] s1_tag;
    logic [2:0]          s1_rm;
    logic                s1_special;
    logic                s1_sub_sign;

    logic [PARM_TAG-1:0] s2_tag;
    logic [2:0]          s2_rm;
    logic                s2_special;
    logic                s2_sub_sign;

    logic [PARM_TAG-1:0] s3_tag;
    logic [2:0]          s3_rm;
    logic                s3_special;
    logic                s3_sub_sign;
    logic                s3_sign_flip;

    // advance conditions
    logic                hold_free3;
    logic                s2_adv;
    logic                s1_adv;
    logic                accept;
    logic                req_sub_sign;

    // Effective subtraction of the incoming operation: product sign after
    // the op's negate-product bit, compared with addend sign after the
    // op's negate-addend bit.
    always_comb begin
        req_sub_sign = (req_sign_a_i ^ req_sign_b_i ^ req_op_i[1])
                     ^ (req_sign_c_i ^ req_op_i[0]);
    end

    // Stage advance chain, evaluated from the output end backwards so a
    // result leaving S3 frees room for the whole pipe in the same cycle.
    // Flush blocks acceptance and masks every enable.
    always_comb begin
        hold_free3  = ~s3_valid | res_ready_i;
        s2_adv      = s2_valid & hold_free3;
        s1_adv      = s1_valid & (~s2_valid | s2_adv);
        req_ready_o = ~flush_i & (~s1_valid | s1_adv);
        accept      = req_valid_i & req_ready_o;
        s1_en_o     = accept;
        s2_en_o     = ~flush_i & s1_adv;
        s3_en_o     = ~flush_i & s2_adv;
    end

    // Valid bits: flush empties the pipe; otherwise a stage is filled by
    // its upstream enable or keeps its operation while it cannot advance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= s1_en_o | (s1_valid & ~s1_adv);
            s2_valid <= s2_en_o | (s2_valid & ~s2_adv);
            s3_valid <= s3_en_o | (s3_valid & ~res_ready_i);
        end
    end

    // S1 sideband: captured from the request on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_tag      <= '0;
            s1_rm       <= '0;
            s1_special  <= 1'b0;
            s1_sub_sign <= 1'b0;
        end else if (s1_en_o) begin
            s1_tag      <= req_tag_i;
            s1_rm       <= req_rm_i;
            s1_special  <= req_special_i;
            s1_sub_sign <= req_sub_sign;
        end
    end

    // S2 sideband: copied from S1 when S1 advances.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_tag      <= '0;
            s2_rm       <= '0;
            s2_special  <= 1'b0;
            s2_sub_sign <= 1'b0;
        end else if (s2_en_o) begin
            s2_tag      <= s1_tag;
            s2_rm       <= s1_rm;
            s2_special  <= s1_special;
            s2_sub_sign <= s1_sub_sign;
        end
    end

    // S3 sideband: copied from S2 plus the adder's sign-flip when S2 advances.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s3_tag       <= '0;
            s3_rm        <= '0;
            s3_special   <= 1'b0;
            s3_sub_sign  <= 1'b0;
            s3_sign_flip <= 1'b0;
        end else if (s3_en_o) begin
            s3_tag       <= s2_tag;
            s3_rm        <= s2_rm;
            s3_special   <= s2_special;
            s3_sub_sign  <= s2_sub_sign;
            s3_sign_flip <= s2_sign_flip_i;
        end
    end

    // Outputs: all registered except the handshake/enable logic above.
    // s2_sub_sign_o shows S2's field even when S2 holds a bubble; the
    // datapath only uses it while S2 is valid. S3's sub_sign is kept for
    // the rounding stage's use but is not exported.
    always_comb begin
        s2_sub_sign_o   = s2_sub_sign;
        res_valid_o     = s3_valid;
        res_tag_o       = s3_tag;
        res_rm_o        = s3_rm;
        res_special_o   = s3_special;
        res_sign_flip_o = s3_sign_flip;
        occupancy_o     = 2'(s1_valid) + 2'(s2_valid) + 2'(s3_valid);
        busy_o          = s1_valid | s2_valid | s3_valid;
    end

    // s3_sub_sign is held for debug visibility of the S3 record.
    logic s3_sub_sign_unused;
    always_comb begin
        s3_sub_sign_unused = s3_sub_sign;
    end

endmodule

// File: tb/tb_mac_issue_ctrl.sv
// tb_mac_issue_ctrl: directed scenarios followed by a random run, all
// compared each cycle against an in-order operation list where every
// operation carries its pipeline position.
module tb_mac_issue_ctrl;

    localparam int TW = 5;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic [1:0]    req_op_i = '0;
    logic [2:0]    req_rm_i = '0;
    logic [TW-1:0] req_tag_i = '0;
    logic          req_sign_a_i = 1'b0;
    logic          req_sign_b_i = 1'b0;
    logic          req_sign_c_i = 1'b0;
    logic          req_special_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          s1_en_o, s2_en_o, s3_en_o;
    logic          s2_sub_sign_o;
    logic          s2_sign_flip_i = 1'b0;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [TW-1:0] res_tag_o;
    logic [2:0]    res_rm_o;
    logic          res_special_o;
    logic          res_sign_flip_o;
    logic [1:0]    occupancy_o;
    logic          busy_o;

    mac_issue_ctrl #(.PARM_TAG(TW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_rm_i(req_rm_i), .req_tag_i(req_tag_i),
        .req_sign_a_i(req_sign_a_i), .req_sign_b_i(req_sign_b_i),
        .req_sign_c_i(req_sign_c_i), .req_special_i(req_special_i),
        .flush_i(flush_i),
        .s1_en_o(s1_en_o), .s2_en_o(s2_en_o), .s3_en_o(s3_en_o),
        .s2_sub_sign_o(s2_sub_sign_o), .s2_sign_flip_i(s2_sign_flip_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_tag_o(res_tag_o), .res_rm_o(res_rm_o),
        .res_special_o(res_special_o), .res_sign_flip_o(res_sign_flip_o),
        .occupancy_o(occupancy_o), .busy_o(busy_o)
    );

    // clock
    always #5 clk_i = ~clk_i;

    // reference: operations in acceptance order, each with its stage (1..3)
    typedef struct {
        logic [TW-1:0] tag;
        logic [2:0]    rm;
        logic          sp;
        logic          sub;
        logic          flip;
        int            pos;
    } op_t;

    op_t mq[$];
    int  total = 0;
    int  bad = 0;
    bit  last_acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit v, input logic [TW-1:0] tag, input logic [1:0] op,
                           input bit sa, input bit sb, input bit sc,
                           input logic [2:0] rm, input bit sp);
        req_valid_i   = v;
        req_tag_i     = tag;
        req_op_i      = op;
        req_sign_a_i  = sa;
        req_sign_b_i  = sb;
        req_sign_c_i  = sc;
        req_rm_i      = rm;
        req_special_i = sp;
    endtask

    // One clock cycle: inputs are already driven (just after a rising edge).
    // Checks current outputs against the list, works out which operations
    // move this cycle, then steps the clock and commits the new list.
    task automatic cycle();
        op_t nq[$];
        op_t o;
        int  blocked;
        bit  acc, e2, e3, exp_rv;
        #1;
        chk("occupancy", occupancy_o, mq.size());
        chk("busy", busy_o, mq.size() != 0);
        exp_rv = (mq.size() > 0) && (mq[0].pos == 3);
        chk("res_valid", res_valid_o, exp_rv);
        if (exp_rv) begin
            chk("res_tag", res_tag_o, mq[0].tag);
            chk("res_rm", res_rm_o, mq[0].rm);
            chk("res_special", res_special_o, mq[0].sp);
            chk("res_sign_flip", res_sign_flip_o, mq[0].flip);
        end
        foreach (mq[i]) if (mq[i].pos == 2) chk("s2_sub_sign", s2_sub_sign_o, mq[i].sub);

        acc = 0; e2 = 0; e3 = 0; blocked = 4;
        if (!flush_i) begin
            foreach (mq[i]) begin
                o = mq[i];
                if (o.pos == 3) begin
                    if (res_ready_i) blocked = 4;
                    else begin blocked = 3; nq.push_back(o); end
                end else if (o.pos + 1 < blocked) begin
                    if (o.pos == 2) begin e3 = 1; o.flip = s2_sign_flip_i; end
                    else e2 = 1;
                    o.pos++;
                    blocked = o.pos;
                    nq.push_back(o);
                end else begin
                    blocked = o.pos;
                    nq.push_back(o);
                end
            end
            acc = req_valid_i && (blocked > 1);
            if (acc) begin
                o.tag  = req_tag_i;
                o.rm   = req_rm_i;
                o.sp   = req_special_i;
                o.sub  = (req_sign_a_i ^ req_sign_b_i ^ req_op_i[1]) ^ (req_sign_c_i ^ req_op_i[0]);
                o.flip = 1'b0;
                o.pos  = 1;
                nq.push_back(o);
            end
        end
        chk("req_ready", req_ready_o, !flush_i && (blocked > 1));
        chk("s1_en", s1_en_o, acc);
        chk("s2_en", s2_en_o, e2);
        chk("s3_en", s3_en_o, e3);
        last_acc = acc;
        @(posedge clk_i);
        #1;
        mq = nq;
    endtask

    logic [TW-1:0] rt;
    logic [1:0]    rop;
    logic [2:0]    rrm;
    bit            ra, rb, rc, rsp;

    initial begin
        // reset
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("rst_res_valid", res_valid_o, 0);
        chk("rst_res_tag", res_tag_o, 0);
        chk("rst_occupancy", occupancy_o, 0);
        chk("rst_busy", busy_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        mq.delete();

        // single op: FMSUB with all signs positive is an effective subtract
        res_ready_i = 1;
        set_req(1, 5, 2'b01, 0, 0, 0, 3'd3, 0);
        cycle();
        req_valid_i = 0;
        cycle();
        chk("single_s2_sub_sign", s2_sub_sign_o, 1);
        cycle();
        chk("single_res_valid", res_valid_o, 1);
        chk("single_res_tag", res_tag_o, 5);
        cycle();
        chk("single_res_gone", res_valid_o, 0);

        // back-to-back: tags 1..6, results on consecutive cycles
        for (int j = 0; j <= 9; j++) begin
            if (j >= 3 && j <= 8) begin
                chk("b2b_res_valid", res_valid_o, 1);
                chk("b2b_res_tag", res_tag_o, j - 2);
            end
            if (j == 9) chk("b2b_res_end", res_valid_o, 0);
            if (j < 6) begin
                set_req(1, TW'(j + 1), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                        1'($urandom), 3'($urandom), 1'($urandom));
                #1 chk("b2b_ready", req_ready_o, 1);
            end else req_valid_i = 0;
            cycle();
        end

        // backpressure: three fit, fourth waits until the result drains
        res_ready_i = 0;
        for (int j = 0; j < 3; j++) begin
            set_req(1, TW'(10 + j), 2'b00, 0, 1, 0, 3'd1, 0);
            cycle();
        end
        set_req(1, 13, 2'b11, 1, 1, 0, 3'd4, 1);
        #1;
        chk("bp_occupancy", occupancy_o, 3);
        chk("bp_ready_low", req_ready_o, 0);
        cycle();
        res_ready_i = 1;
        #1 chk("bp_ready_same_cycle", req_ready_o, 1);
        cycle();
        req_valid_i = 0;
        repeat (5) cycle();

        // flush with a full pipe and a request pending
        res_ready_i = 0;
        for (int j = 0; j < 3; j++) begin
            set_req(1, TW'(16 + j), 2'b10, 0, 0, 1, 3'd2, 1);
            cycle();
        end
        flush_i = 1;
        set_req(1, 19, 2'b00, 0, 0, 0, 3'd0, 0);
        #1 chk("flush_ready", req_ready_o, 0);
        cycle();
        flush_i = 0;
        req_valid_i = 0;
        chk("flush_occupancy", occupancy_o, 0);
        res_ready_i = 1;
        for (int j = 0; j < 3; j++) begin
            chk("flush_no_result", res_valid_o, 0);
            cycle();
        end

        // bubble: accepts at cycles 0 and 2, sign-flip only while the first is in S2
        for (int c = 0; c <= 5; c++) begin
            if (c == 3) begin
                chk("bubble_res0_valid", res_valid_o, 1);
                chk("bubble_res0_tag", res_tag_o, 20);
                chk("bubble_res0_flip", res_sign_flip_o, 1);
            end
            if (c == 4) chk("bubble_gap", res_valid_o, 0);
            if (c == 5) begin
                chk("bubble_res1_valid", res_valid_o, 1);
                chk("bubble_res1_tag", res_tag_o, 21);
                chk("bubble_res1_flip", res_sign_flip_o, 0);
            end
            if (c == 0) set_req(1, 20, 2'b00, 0, 0, 0, 3'd5, 0);
            else if (c == 2) set_req(1, 21, 2'b01, 1, 0, 0, 3'd6, 1);
            else req_valid_i = 0;
            s2_sign_flip_i = (c == 2);
            cycle();
        end
        cycle();

        // reset mid-flight at occupancy 2
        res_ready_i = 0;
        set_req(1, 25, 2'b00, 0, 0, 0, 3'd7, 1);
        cycle();
        set_req(1, 26, 2'b01, 0, 0, 0, 3'd7, 1);
        cycle();
        req_valid_i = 0;
        cycle();
        chk("mid_occupancy", occupancy_o, 2);
        #2 rst_i = 1'b1;
        #1;
        chk("mid_rst_res_valid", res_valid_o, 0);
        chk("mid_rst_res_tag", res_tag_o, 0);
        chk("mid_rst_res_rm", res_rm_o, 0);
        chk("mid_rst_res_special", res_special_o, 0);
        chk("mid_rst_res_flip", res_sign_flip_o, 0);
        chk("mid_rst_occupancy", occupancy_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        #1 rst_i = 1'b0;
        mq.delete();
        @(posedge clk_i);
        #1;

        // random traffic; a pending request keeps its payload until taken
        last_acc = 0;
        for (int n = 0; n < 600; n++) begin
            if (!(req_valid_i && !last_acc)) begin
                rt  = TW'($urandom);
                rop = 2'($urandom);
                rrm = 3'($urandom);
                ra = 1'($urandom); rb = 1'($urandom); rc = 1'($urandom); rsp = 1'($urandom);
                set_req($urandom_range(0, 9) < 6, rt, rop, ra, rb, rc, rrm, rsp);
            end
            res_ready_i    = $urandom_range(0, 3) != 0;
            flush_i        = $urandom_range(0, 29) == 0;
            s2_sign_flip_i = 1'($urandom);
            cycle();
        end
        flush_i = 0;
        req_valid_i = 0;
        res_ready_i = 1;
        repeat (4) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mac_issue_ctrl.md
MAC_ISSUE_CTRL -- requirements
Module: mac_issue_ctrl

Interface
REQ-001 The block SHALL expose parameter PARM_TAG, default 5, the width of the operation tag.
REQ-002 The block SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit, the reset; asynchronous, active-high.
REQ-004 The block SHALL have port req_valid_i, input, 1 bit, an FMA request is presented.
REQ-005 The block SHALL have port req_ready_o, output, 1 bit, the request is accepted this cycle.
REQ-006 The block SHALL have ports req_op_i (input, 2 bits: 00 FMADD, 01 FMSUB, 10 FNMSUB, 11 FNMADD), req_rm_i (input, 3 bits, rounding mode) and req_tag_i (input, PARM_TAG bits).
REQ-007 The block SHALL have ports req_sign_a_i, req_sign_b_i, req_sign_c_i, each input, 1 bit, operand signs.
REQ-008 The block SHALL have port req_special_i, input, 1 bit, any operand Inf, NaN or Zero.
REQ-009 The block SHALL have port flush_i, input, 1 bit, discard all in-flight operations.
REQ-010 The block SHALL have ports s1_en_o, s2_en_o and s3_en_o, each output, 1 bit, load enables for datapath stage registers S1 (multiply/align), S2 (grand add/LZA) and S3 (normalize/round).
REQ-011 The block SHALL have port s2_sub_sign_o, output, 1 bit, effective subtraction for the operation in S2.
REQ-012 The block SHALL have port s2_sign_flip_i, input, 1 bit, the adder sign-flip result of the operation in S2.
REQ-013 The block SHALL have ports res_valid_o (output, 1 bit), res_ready_i (input, 1 bit), res_tag_o (output, PARM_TAG bits), res_rm_o (output, 3 bits), res_special_o (output, 1 bit) and res_sign_flip_o (output, 1 bit), describing the result held in S3.
REQ-014 The block SHALL have ports occupancy_o (output, 2 bits, number of valid stages, 0..3) and busy_o (output, 1 bit, occupancy_o != 0).

Function
REQ-015 The block SHALL keep a valid bit and a sideband field per stage: tag, rm, special, sub_sign; S3 additionally keeps sign_flip.
REQ-016 The block SHALL compute sub_sign = (sign_a ^ sign_b ^ op[1]) ^ (sign_c ^ op[0]) at acceptance and store it in S1.
REQ-017 The block SHALL let S3 advance (hold_free3) when S3 is empty or res_ready_i is 1.
REQ-018 The block SHALL let S2 advance when S2 holds valid and hold_free3, and let S1 advance when S1 holds valid and (S2 is empty or S2 advances); stages collapse bubbles.
REQ-019 The block SHALL drive req_ready_o = ~flush_i & (S1 empty | S1 advances), combinationally.
REQ-020 The block SHALL accept a request on a cycle with req_valid_i & req_ready_o and load S1 on that edge.
REQ-021 The block SHALL assert s1_en_o on acceptance, s2_en_o when S1 advances, and s3_en_o when S2 advances.
REQ-022 The block SHALL latch s2_sign_flip_i into S3 on the edge S2 advances.
REQ-023 The block SHALL have a latency of exactly 3 edges: res_valid_o rises after the third rising edge counting the acceptance edge, when the pipe is not stalled.
REQ-024 The block SHALL hold res_valid_o and all res_* fields stable while res_valid_o=1 and res_ready_i=0.
REQ-025 The block SHALL accept a new request on the same cycle that a result leaves S3 when the pipe is full (throughput 1/cycle).
REQ-026 The block SHALL, on flush_i=1, clear all valid bits at the next edge, accept nothing, and deassert all *_en_o in that cycle; flush has priority over every advance.
REQ-027 The block SHALL drive s2_sub_sign_o from S2's sub_sign field whether or not S2 is valid.
REQ-028 The block SHALL compute occupancy_o from the registered valid bits only.

Reset
REQ-029 The block SHALL, while rst_i=1, clear all valid bits and sideband fields asynchronously.
REQ-030 The block SHALL, while rst_i=1, drive res_valid_o=0, res_tag_o=0, res_rm_o=0, res_special_o=0, res_sign_flip_o=0, occupancy_o=0 and busy_o=0.
REQ-031 The block SHALL discard any operation in flight when reset asserts mid-operation.

Verification
REQ-032 The bench SHALL check single op: tag 5, op 01, signs 0/0/0, res_ready_i=1 -> s2_sub_sign_o=1 two edges after acceptance; res_valid_o=1 with res_tag_o=5 after edge 3 for one cycle.
REQ-033 The bench SHALL check back-to-back flow: tags 1..6 on consecutive cycles, res_ready_i=1 -> req_ready_o constantly 1; results 1..6 appear on consecutive cycles in order.
REQ-034 The bench SHALL check backpressure: 4 requests issued with res_ready_i=0 -> 3 accepted, occupancy_o=3, req_ready_o=0; res_ready_i then raised -> 4th request accepted the same cycle.
REQ-035 The bench SHALL check flush: occupancy 3 with flush_i=1 for one cycle and req_valid_i=1 -> req_ready_o=0, occupancy_o=0 after the edge, no res_valid_o.
REQ-036 The bench SHALL check a bubble: accept at cycles 0 and 2 with res_ready_i=1 -> results at cycles 3 and 5; s2_sign_flip_i=1 at cycle 2 -> res_sign_flip_o=1 for the first result only.
REQ-037 The bench SHALL check reset mid-flight: rst_i pulse at occupancy 2 -> all outputs 0 immediately, without waiting for a clock edge.
